// File: rtl/aes_text_out_unloader_if.sv
// Word stream from the AES result unloader toward a narrow consumer.
// Master drives valid/data/last; slave returns ready.
interface aes_text_out_unloader_if #(
  parameter int WORD_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/aes_text_out_unloader.sv
// Captures the AES text_out block on done and streams it out
// as WORD_W words over valid/ready, flagging dropped blocks.
module aes_text_out_unloader #(
  parameter int DATA_W    = 128,
  parameter int WORD_W    = 32,
  parameter int MSW_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done,
  input  logic [DATA_W-1:0]       text_out,
  aes_text_out_unloader_if.master dout,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  localparam int NW = DATA_W / WORD_W;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;

  logic              hs;
  logic              fin;
  logic              load;
  logic [IW-1:0]     idx_nx;

  function automatic logic [WORD_W-1:0] word_of(
    input logic [DATA_W-1:0] blk,
    input logic [IW-1:0]     i
  );
    int base;
    if (MSW_FIRST != 0)
      base = (NW - 1 - int'(i)) * WORD_W;
    else
      base = int'(i) * WORD_W;
    return blk[base +: WORD_W];
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    ovr_d   = ovr_q & ~clr_overrun;
    hs      = valid_q & dout.out_ready;
    fin     = hs && (idx_q == LAST);
    idx_nx  = idx_q + IW'(1);
    load    = 1'b0;

    unique case (state_q)
      IDLE: load = done;
      SEND: begin
        // done on the final handshake chains the next block
        if (done && !fin)
          ovr_d = 1'b1;
        if (fin) begin
          load = done;
          if (!done) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end else if (hs) begin
          idx_d  = idx_nx;
          data_d = word_of(hold_q, idx_nx);
          last_d = (idx_nx == LAST);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = SEND;
      hold_d  = text_out;
      idx_d   = '0;
      valid_d = 1'b1;
      data_d  = word_of(text_out, '0);
      last_d  = (LAST == '0);
    end

    busy_d = (state_d == SEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout.out_valid = valid_q;
  assign dout.out_data  = data_q;
  assign dout.out_last  = last_q;
  assign busy           = busy_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_aes_text_out_unloader.sv
// Directed bench for aes_text_out_unloader: one task per scenario,
// MSW-first instance u0 and LSW-first instance u1.
module tb_aes_text_out_unloader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         done0 = 1'b0;
  logic         done1 = 1'b0;
  logic [127:0] text_out = '0;
  logic         busy0, busy1;
  logic         ovr0, ovr1;
  logic         clr0 = 1'b0;
  logic         clr1 = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa [4] = '{32'h00112233, 32'h44556677,
                          32'h8899AABB, 32'hCCDDEEFF};
  logic [31:0] wb [4] = '{32'hDEADBEEF, 32'h01234567,
                          32'h89ABCDEF, 32'hFEDCBA98};
  logic [127:0] blk_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  logic [127:0] blk_b = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;

  aes_text_out_unloader_if #(.WORD_W(32)) i0 ();
  aes_text_out_unloader_if #(.WORD_W(32)) i1 ();

  aes_text_out_unloader #(
    .DATA_W(128), .WORD_W(32), .MSW_FIRST(1)
  ) u0 (
    .clk(clk), .rst(rst), .done(done0),
    .text_out(text_out), .dout(i0.master),
    .busy(busy0), .overrun(ovr0),
    .clr_overrun(clr0)
  );

  aes_text_out_unloader #(
    .DATA_W(128), .WORD_W(32), .MSW_FIRST(0)
  ) u1 (
    .clk(clk), .rst(rst), .done(done1),
    .text_out(text_out), .dout(i1.master),
    .busy(busy1), .overrun(ovr1),
    .clr_overrun(clr1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded", $time);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    i0.out_ready = 1'b1;
    i1.out_ready = 1'b1;
    done0 = 1'b1;
    text_out = blk_a;
    repeat (2) @(negedge clk);
    checks++;
    if ({i0.out_valid, i0.out_last, busy0, ovr0} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b exp 0000",
               {i0.out_valid, i0.out_last, busy0, ovr0});
    end
    checks++;
    if (i0.out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h exp 0", i0.out_data);
    end
    done0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (i0.out_valid !== 1'b0 || i1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_valid: got %b%b exp 00",
               i0.out_valid, i1.out_valid);
    end
  endtask

  task automatic test_single();
    i0.out_ready = 1'b1;
    done0 = 1'b1;
    text_out = blk_a;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done0 = 1'b0;
      checks++;
      if (i0.out_valid !== 1'b1 || i0.out_data !== wa[i]) begin
        errors++;
        $display("FAIL single_word%0d: got v=%b %h exp v=1 %h",
                 i, i0.out_valid, i0.out_data, wa[i]);
      end
      checks++;
      if (i0.out_last !== (i == 3) || busy0 !== 1'b1) begin
        errors++;
        $display("FAIL single_last%0d: got last=%b busy=%b exp last=%b busy=1",
                 i, i0.out_last, busy0, (i == 3));
      end
    end
    @(negedge clk);
    checks++;
    if (i0.out_valid !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got v=%b busy=%b exp 0 0",
               i0.out_valid, busy0);
    end
  endtask

  task automatic test_backpressure();
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int k = 0;
    done0 = 1'b1;
    text_out = blk_a;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      done0 = 1'b0;
      checks++;
      if (i0.out_valid !== 1'b1 || i0.out_data !== wa[k]
          || i0.out_last !== (k == 3)) begin
        errors++;
        $display("FAIL bp_cycle%0d: got v=%b %h l=%b exp v=1 %h l=%b",
                 j, i0.out_valid, i0.out_data, i0.out_last,
                 wa[k], (k == 3));
      end
      i0.out_ready = pat[j];
      if (pat[j]) k++;
    end
    @(negedge clk);
    i0.out_ready = 1'b1;
    checks++;
    if (i0.out_valid !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: got v=%b busy=%b exp 0 0",
               i0.out_valid, busy0);
    end
  endtask

  task automatic test_back_to_back();
    i0.out_ready = 1'b1;
    done0 = 1'b1;
    text_out = blk_a;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done0 = 1'b0;
      if (i == 3) begin
        done0 = 1'b1;
        text_out = blk_b;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done0 = 1'b0;
      checks++;
      if (i0.out_valid !== 1'b1 || i0.out_data !== wb[i]
          || i0.out_last !== (i == 3)) begin
        errors++;
        $display("FAIL b2b_word%0d: got v=%b %h l=%b exp v=1 %h l=%b",
                 i, i0.out_valid, i0.out_data, i0.out_last,
                 wb[i], (i == 3));
      end
    end
    checks++;
    if (ovr0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overrun: got %b exp 0", ovr0);
    end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    i0.out_ready = 1'b1;
    done0 = 1'b1;
    text_out = blk_a;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done0 = 1'b0;
      if (i > 1) begin
        checks++;
        if (i0.out_data !== wa[i] || ovr0 !== 1'b1) begin
          errors++;
          $display("FAIL ovr_word%0d: got %h ovr=%b exp %h ovr=1",
                   i, i0.out_data, ovr0, wa[i]);
        end
      end
      if (i == 1) begin
        done0 = 1'b1;
        text_out = blk_b;
      end
    end
    @(negedge clk);
    checks++;
    if (i0.out_valid !== 1'b0 || ovr0 !== 1'b1) begin
      errors++;
      $display("FAIL ovr_idle: got v=%b ovr=%b exp 0 1",
               i0.out_valid, ovr0);
    end
    done0 = 1'b1;
    text_out = blk_a;
    @(negedge clk);
    done0 = 1'b1;
    clr0 = 1'b1;
    text_out = blk_b;
    @(negedge clk);
    done0 = 1'b0;
    clr0 = 1'b0;
    checks++;
    if (ovr0 !== 1'b1 || i0.out_data !== wa[1]) begin
      errors++;
      $display("FAIL ovr_set_wins: got ovr=%b %h exp 1 %h",
               ovr0, i0.out_data, wa[1]);
    end
    repeat (3) @(negedge clk);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    checks++;
    if (ovr0 !== 1'b0 || i0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got ovr=%b v=%b exp 0 0",
               ovr0, i0.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    i0.out_ready = 1'b1;
    done0 = 1'b1;
    text_out = blk_a;
    @(negedge clk);
    done0 = 1'b1;
    text_out = blk_b;
    @(negedge clk);
    done0 = 1'b0;
    checks++;
    if (i0.out_data !== wa[1] || ovr0 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got %h ovr=%b exp %h 1",
               i0.out_data, ovr0, wa[1]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({i0.out_valid, i0.out_last, busy0, ovr0} !== 4'b0
        || i0.out_data !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async: got %b %h exp 0000 0",
               {i0.out_valid, i0.out_last, busy0, ovr0},
               i0.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (i0.out_valid !== 1'b0 || busy0 !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet%0d: got v=%b busy=%b exp 0 0",
                 i, i0.out_valid, busy0);
      end
    end
  endtask

  task automatic test_lsw_first();
    i1.out_ready = 1'b1;
    done1 = 1'b1;
    text_out = blk_a;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done1 = 1'b0;
      checks++;
      if (i1.out_valid !== 1'b1 || i1.out_data !== wa[3-i]
          || i1.out_last !== (i == 3)) begin
        errors++;
        $display("FAIL lsw_word%0d: got v=%b %h l=%b exp v=1 %h l=%b",
                 i, i1.out_valid, i1.out_data, i1.out_last,
                 wa[3-i], (i == 3));
      end
    end
    @(negedge clk);
    checks++;
    if (i1.out_valid !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL lsw_idle: got v=%b busy=%b exp 0 0",
               i1.out_valid, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_lsw_first();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
